// File: rtl/ypc_pkg.sv
// Shared constants, FSM state type and helpers for the PC sequencer.
// Optional jr support is enabled with the Y_PC_JR_EN macro.
package ypc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [31:0] SYSCALL_WORD = 32'h0000000C;

  typedef enum logic {
    S_RUN,
    S_HALT
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/y_next_pc.sv
// Combinational next-PC selection: jr (optional), j, taken beq, else pc+4.
// Optional jr support is enabled with the Y_PC_JR_EN macro.
module y_next_pc
  import ypc_pkg::*;
(
`ifdef Y_PC_JR_EN
  input  logic [31:0] rd1,
`endif
  input  logic [31:0] pc,
  input  logic [31:0] ins,
  input  logic [31:0] imm,
  input  logic [25:0] jTarget,
  input  logic        zero,
  output logic [31:0] next_pc,
  output logic [31:0] pcp4
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_bits;

  assign op    = ins[31:26];
  assign funct = ins[5:0];

  assign unused_bits = ^{ins[25:6], imm[31:30], funct};

  // Priority select of the next sequential/branch/jump target.
  always_comb begin
    pcp4    = pc + 32'd4;
    next_pc = pcp4;
`ifdef Y_PC_JR_EN
    if (op == OP_RTYPE && funct == FUNCT_JR) begin
      next_pc = rd1;
    end else
`endif
    if (op == OP_J) begin
      next_pc = {pcp4[31:28], jTarget, 2'b00};
    end else if (op == OP_BEQ && zero) begin
      next_pc = pcp4 + {imm[29:0], 2'b00};
    end
  end

endmodule

// File: rtl/y_pc_seq.sv
// PC register, RUN/HALT sequencer and retired-instruction counter.
// Optional jr support (rd1 input, err output) via the Y_PC_JR_EN macro.
module y_pc_seq
  import ypc_pkg::*;
#(
  parameter logic [31:0] ENTRY   = 32'd128,
  parameter logic [31:0] MAX_INS = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        resume,
  input  logic [31:0] ins,
  input  logic [31:0] imm,
  input  logic [25:0] jTarget,
  input  logic        zero,
`ifdef Y_PC_JR_EN
  input  logic [31:0] rd1,
  output logic [0:0]  err,
`endif
  output logic [31:0] pc,
  output logic [31:0] pcp4,
  output logic        halt,
  output logic [31:0] icount
);

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc_nx;
  logic [31:0] cnt_nx;
  logic [31:0] cnt_inc;
  logic [31:0] next_pc;
  logic        is_sys;
  logic        bad_jr;
  logic        budget_hit;
  logic        err_q;
  logic        err_nx;

  y_next_pc u_next (
`ifdef Y_PC_JR_EN
    .rd1     (rd1),
`endif
    .pc      (pc),
    .ins     (ins),
    .imm     (imm),
    .jTarget (jTarget),
    .zero    (zero),
    .next_pc (next_pc),
    .pcp4    (pcp4)
  );

  assign is_sys  = (ins == SYSCALL_WORD);
  assign cnt_inc = sat_inc(icount);

  // A budget halt keeps re-triggering on every later retirement.
  assign budget_hit = (MAX_INS != 32'd0) && (cnt_inc >= MAX_INS);

`ifdef Y_PC_JR_EN
  assign bad_jr = (ins[31:26] == OP_RTYPE) && (ins[5:0] == FUNCT_JR) && (rd1[1:0] != 2'b00);
  assign err    = err_q;
`else
  assign bad_jr = 1'b0;
`endif

  assign halt = (state == S_HALT);

  // State, PC, counter and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_RUN;
      pc     <= ENTRY;
      icount <= 32'd0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      pc     <= pc_nx;
      icount <= cnt_nx;
      err_q  <= err_nx;
    end
  end

  // RUN/HALT transitions; nothing moves while en is low.
  always_comb begin
    state_nx = state;
    if (en) begin
      unique case (state)
        S_RUN: begin
          if (is_sys || bad_jr || budget_hit) begin
            state_nx = S_HALT;
          end
        end
        S_HALT: begin
          if (resume) begin
            state_nx = S_RUN;
          end
        end
      endcase
    end
  end

  // Register updates implied by the current state and inputs.
  always_comb begin
    pc_nx  = pc;
    cnt_nx = icount;
    err_nx = err_q;
    if (en) begin
      unique case (state)
        S_RUN: begin
          if (bad_jr) begin
            err_nx = 1'b1;
          end else begin
            cnt_nx = cnt_inc;
            if (!is_sys) begin
              pc_nx = next_pc;
            end
          end
        end
        S_HALT: begin
          if (resume) begin
            pc_nx  = pcp4;
            err_nx = 1'b0;
          end
        end
      endcase
    end
  end

endmodule
